// File: rtl/img_ctrl_pkg.sv
// Shared types for the image-buffer controller: command codes and FSM states.
package img_ctrl_pkg;

    typedef enum logic [3:0] {
        CMD_WRTBK  = 4'd0,
        CMD_UP     = 4'd1,
        CMD_DN     = 4'd2,
        CMD_LF     = 4'd3,
        CMD_RT     = 4'd4,
        CMD_AVG    = 4'd5,
        CMD_MRR_X  = 4'd6,
        CMD_MRR_Y  = 4'd7,
        CMD_MAX    = 4'd8,
        CMD_MIN    = 4'd9,
        CMD_CENTER = 4'd10,
        CMD_ROT    = 4'd11
    } cmd_e;

    typedef enum logic [1:0] {
        ST_LOAD,
        ST_READY,
        ST_WRITE,
        ST_DONE
    } state_e;

endpackage

// File: rtl/img_win_alu.sv
// Combinational 2x2 window operator: average, mirror, max/min and, with
// IMG_CTRL_ROT_EN defined, clockwise rotate. P1..P4 = TL, TR, BL, BR.
module img_win_alu
    import img_ctrl_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic [3:0]    cmd,
    input  logic [DW-1:0] p1,
    input  logic [DW-1:0] p2,
    input  logic [DW-1:0] p3,
    input  logic [DW-1:0] p4,
    output logic [DW-1:0] q1,
    output logic [DW-1:0] q2,
    output logic [DW-1:0] q3,
    output logic [DW-1:0] q4,
    output logic          we
);

    logic [DW+1:0] sum;
    logic [DW-1:0] avg;
    logic [DW-1:0] mx01, mx23, mx, mn01, mn23, mn;

    always_comb begin
        // Two guard bits keep four full-scale pixels from wrapping.
        sum  = {2'b00, p1} + {2'b00, p2} + {2'b00, p3} + {2'b00, p4};
        avg  = DW'(sum >> 2);
        mx01 = (p1 > p2) ? p1 : p2;
        mx23 = (p3 > p4) ? p3 : p4;
        mx   = (mx01 > mx23) ? mx01 : mx23;
        mn01 = (p1 < p2) ? p1 : p2;
        mn23 = (p3 < p4) ? p3 : p4;
        mn   = (mn01 < mn23) ? mn01 : mn23;
    end

    always_comb begin
        q1 = p1;
        q2 = p2;
        q3 = p3;
        q4 = p4;
        we = 1'b0;
        case (cmd_e'(cmd))
            CMD_AVG: begin
                q1 = avg; q2 = avg; q3 = avg; q4 = avg; we = 1'b1;
            end
            CMD_MRR_X: begin
                q1 = p3; q2 = p4; q3 = p1; q4 = p2; we = 1'b1;
            end
            CMD_MRR_Y: begin
                q1 = p2; q2 = p1; q3 = p4; q4 = p3; we = 1'b1;
            end
            CMD_MAX: begin
                q1 = mx; q2 = mx; q3 = mx; q4 = mx; we = 1'b1;
            end
            CMD_MIN: begin
                q1 = mn; q2 = mn; q3 = mn; q4 = mn; we = 1'b1;
            end
`ifdef IMG_CTRL_ROT_EN
            CMD_ROT: begin
                q1 = p3; q2 = p1; q4 = p2; q3 = p4; we = 1'b1;
            end
`endif
            default: ;
        endcase
    end

endmodule

// File: rtl/img_ctrl_p.sv
// Image-buffer controller: ROM load, 2x2 window commands, IRB write-back.
// Optional clockwise window rotate is enabled by defining IMG_CTRL_ROT_EN.
module img_ctrl_p
    import img_ctrl_pkg::*;
#(
    parameter int IMG_W_LOG2 = 3,
    parameter int IMG_H_LOG2 = 3,
    parameter int DW         = 8
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [3:0]                     cmd,
    input  logic                           cmd_valid,
    output logic                           rom_en,
    output logic [IMG_W_LOG2+IMG_H_LOG2-1:0] rom_a,
    input  logic [DW-1:0]                  rom_q,
    output logic                           irb_we,
    output logic [IMG_W_LOG2+IMG_H_LOG2-1:0] irb_a,
    output logic [DW-1:0]                  irb_d,
    output logic                           busy,
    output logic                           done
);

    localparam int AW = IMG_W_LOG2 + IMG_H_LOG2;
    localparam int N  = 1 << AW;
    localparam logic [AW:0]           N_CNT = (AW+1)'(N);
    localparam logic [AW-1:0]         LAST  = AW'(N - 1);
    localparam logic [IMG_H_LOG2-1:0] Y_MIN = IMG_H_LOG2'(1);
    localparam logic [IMG_H_LOG2-1:0] Y_MAX = '1;
    localparam logic [IMG_H_LOG2-1:0] Y_CTR = IMG_H_LOG2'(1 << (IMG_H_LOG2 - 1));
    localparam logic [IMG_W_LOG2-1:0] X_MIN = IMG_W_LOG2'(1);
    localparam logic [IMG_W_LOG2-1:0] X_MAX = '1;
    localparam logic [IMG_W_LOG2-1:0] X_CTR = IMG_W_LOG2'(1 << (IMG_W_LOG2 - 1));

    state_e state, nxt;
    logic [AW:0]           ld_cnt, wr_cnt;
    logic                  cap_vld;
    logic [AW-1:0]         cap_a;
    logic [IMG_H_LOG2-1:0] opy;
    logic [IMG_W_LOG2-1:0] opx;
    logic [DW-1:0]         img [N];

    logic                  acc;
    logic [AW-1:0]         i1, i2, i3, i4;
    logic [DW-1:0]         q1, q2, q3, q4;
    logic                  alu_we;

    assign acc = cmd_valid && (state == ST_READY);
    assign i1  = {opy - Y_MIN, opx - X_MIN};
    assign i2  = {opy - Y_MIN, opx};
    assign i3  = {opy, opx - X_MIN};
    assign i4  = {opy, opx};

    img_win_alu #(.DW(DW)) u_alu (
        .cmd (cmd),
        .p1  (img[i1]),
        .p2  (img[i2]),
        .p3  (img[i3]),
        .p4  (img[i4]),
        .q1  (q1),
        .q2  (q2),
        .q3  (q3),
        .q4  (q4),
        .we  (alu_we)
    );

    always_comb begin
        nxt = state;
        case (state)
            ST_LOAD:  if (cap_vld && cap_a == LAST) nxt = ST_READY;
            ST_READY: if (acc && cmd_e'(cmd) == CMD_WRTBK) nxt = ST_WRITE;
            ST_WRITE: if (wr_cnt == N_CNT) nxt = ST_DONE;
            default:  nxt = ST_DONE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ST_LOAD;
            ld_cnt  <= '0;
            wr_cnt  <= '0;
            cap_vld <= 1'b0;
            cap_a   <= '0;
            opy     <= Y_CTR;
            opx     <= X_CTR;
            rom_en  <= 1'b0;
            rom_a   <= '0;
            irb_we  <= 1'b0;
            irb_a   <= '0;
            irb_d   <= '0;
            busy    <= 1'b1;
            done    <= 1'b0;
        end else begin
            state   <= nxt;
            cap_vld <= rom_en;
            cap_a   <= rom_a;
            rom_en  <= 1'b0;
            irb_we  <= 1'b0;
            // busy stays up for the first READY cycle so it drops one cycle after the last capture
            busy    <= (nxt == ST_LOAD) || (nxt == ST_WRITE) || (state == ST_LOAD);
            done    <= (nxt == ST_DONE);

            if (state == ST_LOAD && ld_cnt != N_CNT) begin
                rom_en <= 1'b1;
                rom_a  <= ld_cnt[AW-1:0];
                ld_cnt <= ld_cnt + 1'b1;
            end

            if (state == ST_WRITE && wr_cnt != N_CNT) begin
                irb_we <= 1'b1;
                irb_a  <= wr_cnt[AW-1:0];
                irb_d  <= img[wr_cnt[AW-1:0]];
                wr_cnt <= wr_cnt + 1'b1;
            end

            if (acc) begin
                case (cmd_e'(cmd))
                    CMD_UP:     if (opy != Y_MIN) opy <= opy - 1'b1;
                    CMD_DN:     if (opy != Y_MAX) opy <= opy + 1'b1;
                    CMD_LF:     if (opx != X_MIN) opx <= opx - 1'b1;
                    CMD_RT:     if (opx != X_MAX) opx <= opx + 1'b1;
                    CMD_CENTER: begin opy <= Y_CTR; opx <= X_CTR; end
                    default: ;
                endcase
            end
        end
    end

    // Buffer has no reset: it is fully rewritten by every load.
    always_ff @(posedge clk) begin
        if (cap_vld) img[cap_a] <= rom_q;
        if (acc && alu_we) begin
            img[i1] <= q1;
            img[i2] <= q2;
            img[i3] <= q3;
            img[i4] <= q4;
        end
    end

endmodule

// File: tb/tb_img_ctrl_p.sv
// Scoreboard bench for img_ctrl_p: a behavioural image model predicts the write-back stream.
module tb_img_ctrl_p;
    localparam int AW = 6, N = 64, COLS = 8, DW = 8;

    logic          clk = 1'b0, reset = 1'b1, cmd_valid = 1'b0;
    logic [3:0]    cmd = 4'd0;
    logic          rom_en, irb_we, busy, done;
    logic [AW-1:0] rom_a, irb_a;
    logic [DW-1:0] rom_q, irb_d;
    logic [DW-1:0] rom_mem [N];

    int m_img [N];
    int m_opy, m_opx;
    int errors = 0, checks = 0;
    typedef struct { int a; int d; } wr_t;
    wr_t sb [$];

    img_ctrl_p #(.IMG_W_LOG2(3), .IMG_H_LOG2(3), .DW(DW)) dut (
        .clk(clk), .reset(reset), .cmd(cmd), .cmd_valid(cmd_valid),
        .rom_en(rom_en), .rom_a(rom_a), .rom_q(rom_q),
        .irb_we(irb_we), .irb_a(irb_a), .irb_d(irb_d),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) if (rom_en) rom_q <= rom_mem[rom_a];

    task automatic set_rom(input bit ff);
        for (int i = 0; i < N; i++) rom_mem[i] = ff ? 8'hFF : 8'(i);
    endtask

    task automatic m_apply(input int c);
        int k1, k2, k3, k4, v1, v2, v3, v4, r;
        k1 = (m_opy - 1) * COLS + (m_opx - 1); k2 = k1 + 1; k3 = k1 + COLS; k4 = k3 + 1;
        v1 = m_img[k1]; v2 = m_img[k2]; v3 = m_img[k3]; v4 = m_img[k4];
        case (c)
            1: if (m_opy > 1) m_opy--;
            2: if (m_opy < 7) m_opy++;
            3: if (m_opx > 1) m_opx--;
            4: if (m_opx < 7) m_opx++;
            5: begin r = (v1 + v2 + v3 + v4) / 4; m_img[k1] = r; m_img[k2] = r; m_img[k3] = r; m_img[k4] = r; end
            6: begin m_img[k1] = v3; m_img[k2] = v4; m_img[k3] = v1; m_img[k4] = v2; end
            7: begin m_img[k1] = v2; m_img[k2] = v1; m_img[k3] = v4; m_img[k4] = v3; end
            8, 9: begin
                r = v1;
                if ((c == 8) ? v2 > r : v2 < r) r = v2;
                if ((c == 8) ? v3 > r : v3 < r) r = v3;
                if ((c == 8) ? v4 > r : v4 < r) r = v4;
                m_img[k1] = r; m_img[k2] = r; m_img[k3] = r; m_img[k4] = r;
            end
            10: begin m_opy = 4; m_opx = 4; end
`ifdef IMG_CTRL_ROT_EN
            11: begin m_img[k1] = v3; m_img[k2] = v1; m_img[k4] = v2; m_img[k3] = v4; end
`endif
            default: ;
        endcase
    endtask

    task automatic do_reset();
        reset = 1'b1; cmd_valid = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, rom_en, rom_a, irb_we, irb_a, irb_d, done} !==
            {1'b1, 1'b0, 6'd0, 1'b0, 6'd0, 8'd0, 1'b0})
            $display("FAIL reset_values: got busy=%b rom_en=%b rom_a=%0d irb_we=%b irb_a=%0d irb_d=%0d done=%b, want 1 0 0 0 0 0 0",
                     busy, rom_en, rom_a, irb_we, irb_a, irb_d, done);
        if ({busy, rom_en, rom_a, irb_we, irb_a, irb_d, done} !== {1'b1, 1'b0, 6'd0, 1'b0, 6'd0, 8'd0, 1'b0}) errors++;
        for (int i = 0; i < N; i++) m_img[i] = int'(rom_mem[i]);
        m_opy = 4; m_opx = 4;
        sb.delete();
        reset = 1'b0;
    endtask

    // Commands driven during the load must be ignored.
    task automatic wait_ready(input bit junk);
        int exp_a = 0, fall = -1;
        bit ok = 1'b1;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (rom_en) begin
                if (rom_a !== exp_a[AW-1:0] || c != exp_a) ok = 1'b0;
                exp_a++;
            end
            if (done !== 1'b0) ok = 1'b0;
            cmd = 4'd8; cmd_valid = junk && (c < 64);
            if (busy === 1'b0) begin fall = c; break; end
        end
        cmd_valid = 1'b0;
        checks++;
        if (!ok || exp_a != N) begin
            errors++;
            $display("FAIL rom_sweep: reads=%0d in_order=%0d, want 64 in order with done=0", exp_a, ok);
        end
        checks++;
        if (fall != N + 2) begin
            errors++;
            $display("FAIL busy_fall: busy fell in cycle %0d, want %0d", fall, N + 2);
        end
    endtask

    task automatic send(input int c);
        cmd = 4'(c); cmd_valid = 1'b1;
        m_apply(c);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    // AVG strobes during write-back and DONE must not disturb the stream.
    task automatic writeback(input bit junk, input string tag);
        wr_t e;
        bit drained = 1'b0;
        send(0);
        checks++;
        if (busy !== 1'b1 || irb_we !== 1'b0) begin
            errors++;
            $display("FAIL %s wb_busy: busy=%b irb_we=%b, want 1 0", tag, busy, irb_we);
        end
        for (int j = 0; j < N; j++) sb.push_back('{j, m_img[j]});
        cmd = 4'd5; cmd_valid = junk;
        for (int c = 0; c < 100 && !drained; c++) begin
            @(negedge clk);
            if (irb_we === 1'b1) begin
                e = sb.pop_front();
                checks++;
                if (irb_a !== e.a[AW-1:0] || irb_d !== e.d[DW-1:0]) begin
                    errors++;
                    $display("FAIL %s irb_write: got a=%0d d=%0d, want a=%0d d=%0d", tag, irb_a, irb_d, e.a, e.d);
                end
                if (sb.size() == 0) drained = 1'b1;
            end
        end
        checks++;
        if (!drained) begin
            errors++;
            $display("FAIL %s wb_timeout: %0d writes missing", tag, sb.size());
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || irb_we !== 1'b0) begin
            errors++;
            $display("FAIL %s wb_done: done=%b busy=%b irb_we=%b, want 1 0 0", tag, done, busy, irb_we);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (done !== 1'b1 || irb_we !== 1'b0) begin
            errors++;
            $display("FAIL %s done_hold: done=%b irb_we=%b, want 1 0", tag, done, irb_we);
        end
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        set_rom(0); do_reset(); wait_ready(1);
        writeback(1, "ramp");
    endtask

    task automatic test_avg();
        set_rom(0); do_reset(); wait_ready(0);
        send(5); writeback(0, "avg");
    endtask

    task automatic test_back_to_back();
        set_rom(0); do_reset(); wait_ready(0);
        send(6); send(7); writeback(0, "mirror");
    endtask

    task automatic test_max_min();
        set_rom(0); do_reset(); wait_ready(0);
        repeat (5) send(1);
        repeat (5) send(3);
        send(8); writeback(0, "max");
        do_reset(); wait_ready(0);
        repeat (5) send(1);
        repeat (5) send(3);
        send(9); writeback(0, "min");
    endtask

    task automatic test_move();
        set_rom(0); do_reset(); wait_ready(0);
        repeat (6) send(2);
        repeat (6) send(4);
        send(7); send(10);
        for (int c = 12; c < 16; c++) send(c);
        send(6); writeback(0, "move");
    endtask

    task automatic test_overflow();
        set_rom(1); do_reset(); wait_ready(0);
        send(5); send(9); writeback(0, "ovf");
    endtask

    task automatic test_rot();
        set_rom(0); do_reset(); wait_ready(0);
        send(11); writeback(0, "rot");
    endtask

    task automatic test_reset_mid();
        bit hit = 1'b0;
        set_rom(0); do_reset(); wait_ready(0);
        send(0);
        for (int c = 0; c < 100 && !hit; c++) begin
            @(negedge clk);
            if (irb_we === 1'b1 && irb_a === 6'd20) hit = 1'b1;
        end
        reset = 1'b1;
        #1;
        checks++;
        if (!hit || irb_we !== 1'b0 || busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: hit=%0d irb_we=%b busy=%b done=%b, want 1 0 1 0", hit, irb_we, busy, done);
        end
        do_reset(); wait_ready(0);
        send(5); writeback(0, "after_reset");
    endtask

    initial begin
        test_reset();
        test_avg();
        test_back_to_back();
        test_max_min();
        test_move();
        test_overflow();
        test_rot();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
